// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared constants, FSM encoding and lane helpers for the
// memory-stage load/store unit.
package mem_stage_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  // funct3[1:0] gives the access size for both loads and stores:
  // 00 byte, 01 half, anything else is treated as a full word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [BE_W-1:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    logic [BE_W-1:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicating the narrow datum across the word puts it on every lane, so
  // the byte enables alone select where it lands.
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] wd;
    case (f3[1:0])
      2'b00:   wd = {4{data[7:0]}};
      2'b01:   wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: data-memory request/acknowledge bus between the LSU
// (master) and a variable-latency data memory (slave).
interface mem_stage_lsu_if;
  import mem_stage_lsu_pkg::*;

  logic            dmem_req;
  logic            dmem_we;
  logic [31:0]     dmem_addr;
  logic [BE_W-1:0] dmem_be;
  logic [31:0]     dmem_wdata;
  logic [31:0]     dmem_rdata;
  logic            dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// lsu_load_align: selects the addressed lane of a memory read word and
// sign- or zero-extends it according to the load funct3. Purely
// combinational so a future cache read path can share it.
module lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_off, 3'b000};

  // Pick the addressed lane and widen it for the load type; unknown codes load a word
  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_BU:   o_data = {24'd0, w_shifted[7:0]};
      F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_HU:   o_data = {16'd0, w_shifted[15:0]};
      F3_W:    o_data = i_rdata;
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit. Issues one registered request
// per legal access on the data-memory bus, stalls the pipeline until the
// acknowledge (or a timeout abort) and returns the extended load result.
// Optional build macro: LSU_MISALIGN_EXC_EN adds the MisalignM trap pulse.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        BusErrM,
`ifdef LSU_MISALIGN_EXC_EN
  output logic        MisalignM,
`endif
  mem_stage_lsu_if.master dmem
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  lsu_state_t      r_state;
  lsu_state_t      w_nextState;
  logic            r_req;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [BE_W-1:0] r_be;
  logic [31:0]     r_wdata;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic [31:0]     r_cnt;
  logic [31:0]     r_readData;
  logic            r_busErr;

  logic            w_access;
  logic            w_misaligned;
  logic            w_start;
  logic            w_misHit;
  logic            w_timeout;
  logic            w_stall;
  logic [31:0]     w_loadData;

  assign w_access     = MemReadM | MemWriteM;
  assign w_misaligned = is_misaligned(Funct3M, ALUResultM[1:0]);

  lsu_load_align u_align (
    .i_rdata  (dmem.dmem_rdata),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_data   (w_loadData)
  );

  // Next-state decode plus the combinational stall seen by the hazard unit
  always_comb begin
    w_nextState = r_state;
    w_stall     = 1'b0;
    w_start     = 1'b0;
    w_misHit    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      LSU_IDLE: begin
        if (w_access) begin
          if (w_misaligned) begin
            w_misHit = 1'b1;
          end else begin
            w_start     = 1'b1;
            w_stall     = ~reset;
            w_nextState = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        w_stall = 1'b1;
        if (dmem.dmem_ack) begin
          w_nextState = LSU_DONE;
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          w_timeout   = 1'b1;
          w_nextState = LSU_DONE;
        end
      end
      LSU_DONE: w_nextState = LSU_IDLE;
      default:  w_nextState = LSU_IDLE;
    endcase
  end

  // State register; reset abandons any outstanding access immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LSU_IDLE;
    else       r_state <= w_nextState;
  end

  // Request fields, wait counter and load result, updated per FSM phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_be       <= '0;
      r_wdata    <= 32'd0;
      r_funct3   <= 3'd0;
      r_off      <= 2'd0;
      r_cnt      <= 32'd0;
      r_readData <= 32'd0;
      r_busErr   <= 1'b0;
    end else begin
      r_busErr <= 1'b0;
      case (r_state)
        LSU_IDLE: begin
          if (w_start) begin
            r_req    <= 1'b1;
            r_we     <= MemWriteM;
            r_addr   <= {ALUResultM[31:2], 2'b00};
            r_be     <= lane_be(Funct3M, ALUResultM[1:0]);
            r_wdata  <= lane_wdata(Funct3M, WriteDataM);
            r_funct3 <= Funct3M;
            r_off    <= ALUResultM[1:0];
            r_cnt    <= 32'd0;
          end else if (w_misHit) begin
            r_readData <= 32'd0;
          end
        end
        LSU_REQ: begin
          r_cnt <= r_cnt + 32'd1;
          if (dmem.dmem_ack) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            if (!r_we) r_readData <= w_loadData;
          end else if (w_timeout) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_readData <= 32'd0;
            r_busErr   <= 1'b1;
          end
        end
        LSU_DONE: r_cnt <= 32'd0;
        default:  r_cnt <= 32'd0;
      endcase
    end
  end

`ifdef LSU_MISALIGN_EXC_EN
  logic r_misalign;

  // One-cycle trap pulse for a misaligned access seen while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_misalign <= 1'b0;
    else       r_misalign <= w_misHit;
  end

  assign MisalignM = r_misalign;
`endif

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_be    = r_be;
  assign dmem.dmem_wdata = r_wdata;

  assign ReadDataM = r_readData;
  assign StallM    = w_stall;
  assign BusErrM   = r_busErr;

endmodule
